// File: rtl/maxpool2d_channel_pkg.sv
// Shared definitions for the max-pooling stage: FSM state encoding and
// geometry helpers used to size counters and the pooled output map.
package maxpool2d_channel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Pooled dimension along one axis; trailing pixels not covered by a full
  // window are dropped (integer floor).
  function automatic int out_dim(input int in_dim, input int pool, input int stride);
    return (in_dim - pool) / stride + 1;
  endfunction

  // Bits needed to hold an index in 0..n-1 (at least one bit).
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxpool2d_channel_if.sv
// Start/done handshake plus flat feature/pooled buses.
//   calculate_start : level request from the producer
//   feature_in      : flat signed maps, element 0 at the MSBs
//   calculate_done  : result valid / acknowledge
//   pool_out        : flat signed pooled maps, same MSB-first layout
interface maxpool2d_channel_if #(
  parameter int IN_BITS  = 216,
  parameter int OUT_BITS = 96
);
  logic                calculate_start;
  logic [IN_BITS-1:0]  feature_in;
  logic                calculate_done;
  logic [OUT_BITS-1:0] pool_out;

  modport master (output calculate_start, feature_in, input calculate_done, pool_out);
  modport slave  (input calculate_start, feature_in, output calculate_done, pool_out);
endinterface

// File: rtl/maxpool2d_channel_pool_window_max.sv
// Combinational window reducer: signed max over WIN elements, then an
// optional ReLU clamp.
//   win   : WIN signed elements of DW bits
//   max_o : signed maximum (clamped to >= 0 when RELU_EN)
module pool_window_max #(
  parameter int DW      = 8,
  parameter int WIN     = 4,
  parameter int RELU_EN = 1
) (
  input  logic [WIN-1:0][DW-1:0] win,
  output logic [DW-1:0]          max_o
);

  // run[g] is the running max over win[0..g]; a signed compare keeps the
  // most-negative code (e.g. 8'h80) as the minimum.
  logic [WIN-1:0][DW-1:0] run;

  assign run[0] = win[0];

  for (genvar g = 1; g < WIN; g++) begin : g_red
    assign run[g] = ($signed(win[g]) > $signed(run[g-1])) ? win[g] : run[g-1];
  end

  assign max_o = ((RELU_EN != 0) && run[WIN-1][DW-1]) ? '0 : run[WIN-1];

endmodule

// File: rtl/maxpool2d_channel.sv
// Signed 2-D max pooling over CHANNEL_NUM feature maps, one window per clock,
// with optional ReLU. The input is captured on start, windows are walked
// ox -> oy -> ch, and each result lands in its pooled slot.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of maxpool2d_channel_if (start/feature in, done/pool out)
module maxpool2d_channel
  import maxpool2d_channel_pkg::*;
#(
  parameter int BITWIDTH                 = 8,
  parameter int IS_BITWIDTH_DOUBLE_SCALE = 0,
  parameter int IN_WIDTH                 = 3,
  parameter int IN_HEIGHT                = 3,
  parameter int CHANNEL_NUM              = 3,
  parameter int POOL_SIZE                = 2,
  parameter int POOL_STRIDE              = 1,
  parameter int RELU_EN                  = 1
) (
  input logic             clk,
  input logic             rst,
  maxpool2d_channel_if.slave bus
);

  localparam int DW        = BITWIDTH * (IS_BITWIDTH_DOUBLE_SCALE + 1);
  localparam int OUT_W     = out_dim(IN_WIDTH, POOL_SIZE, POOL_STRIDE);
  localparam int OUT_H     = out_dim(IN_HEIGHT, POOL_SIZE, POOL_STRIDE);
  localparam int OUT_NUM   = OUT_W * OUT_H;
  localparam int IN_ELEMS  = IN_WIDTH * IN_HEIGHT * CHANNEL_NUM;
  localparam int OUT_ELEMS = OUT_NUM * CHANNEL_NUM;
  localparam int WIN       = POOL_SIZE * POOL_SIZE;
  localparam int CHW       = idx_w(CHANNEL_NUM);
  localparam int OYW       = idx_w(OUT_H);
  localparam int OXW       = idx_w(OUT_W);
  localparam int IDXW      = idx_w(IN_ELEMS);
  localparam int SLW       = idx_w(OUT_ELEMS);

  // Ascending outer range puts element 0 at the MSBs, matching the bus layout.
  typedef logic [0:IN_ELEMS-1][DW-1:0]  in_map_t;
  typedef logic [0:OUT_ELEMS-1][DW-1:0] out_map_t;

  state_t           state_q, state_d;
  logic             done_q, done_d;
  in_map_t          cap_q, cap_d;
  out_map_t         pool_q, pool_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [OYW-1:0]   oy_q, oy_d;
  logic [OXW-1:0]   ox_q, ox_d;

  logic [WIN-1:0][DW-1:0]  win;
  logic [WIN-1:0][IDXW-1:0] tap_idx;
  logic [DW-1:0]           win_max;
  logic [SLW-1:0]          slot_idx;

  // Window gather: tap k sits at row oy*S + k/P, col ox*S + k%P of channel ch.
  for (genvar k = 0; k < WIN; k++) begin : g_tap
    assign tap_idx[k] = IDXW'((int'(ch_q) * IN_HEIGHT + int'(oy_q) * POOL_STRIDE + k / POOL_SIZE)
                              * IN_WIDTH + int'(ox_q) * POOL_STRIDE + k % POOL_SIZE);
    assign win[k]     = cap_q[tap_idx[k]];
  end

  pool_window_max #(
    .DW      (DW),
    .WIN     (WIN),
    .RELU_EN (RELU_EN)
  ) u_max (
    .win   (win),
    .max_o (win_max)
  );

  assign slot_idx = SLW'((int'(ch_q) * OUT_H + int'(oy_q)) * OUT_W + int'(ox_q));

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    cap_d   = cap_q;
    pool_d  = pool_q;
    ch_d    = ch_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    unique case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (bus.calculate_start) begin
          cap_d   = bus.feature_in;
          ch_d    = '0;
          oy_d    = '0;
          ox_d    = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        pool_d[slot_idx] = win_max;
        if (ox_q == OXW'(OUT_W - 1)) begin
          ox_d = '0;
          if (oy_q == OYW'(OUT_H - 1)) begin
            oy_d = '0;
            if (ch_q == CHW'(CHANNEL_NUM - 1)) begin
              ch_d    = '0;
              state_d = ST_DONE;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end else begin
            oy_d = oy_q + 1'b1;
          end
        end else begin
          ox_d = ox_q + 1'b1;
        end
      end
      ST_DONE: begin
        // done rises one edge after the last write and is held while the
        // requester keeps start high.
        if (bus.calculate_start) begin
          done_d = 1'b1;
        end else begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      cap_q   <= '0;
      pool_q  <= '0;
      ch_q    <= '0;
      oy_q    <= '0;
      ox_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cap_q   <= cap_d;
      pool_q  <= pool_d;
      ch_q    <= ch_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
    end
  end

  assign bus.calculate_done = done_q;
  assign bus.pool_out       = pool_q;

endmodule

// File: tb/tb_maxpool2d_channel.sv
module tb_maxpool2d_channel;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // a: defaults (ReLU on), b: ReLU off, c: 4x4 map, pool 2, stride 2, one channel
  maxpool2d_channel_if #(.IN_BITS(216), .OUT_BITS(96)) ia ();
  maxpool2d_channel_if #(.IN_BITS(216), .OUT_BITS(96)) ib ();
  maxpool2d_channel_if #(.IN_BITS(128), .OUT_BITS(32)) ic ();

  maxpool2d_channel dut_a (.clk(clk), .rst(rst), .bus(ia));
  maxpool2d_channel #(.RELU_EN(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  maxpool2d_channel #(.IN_WIDTH(4), .IN_HEIGHT(4), .CHANNEL_NUM(1),
                      .POOL_SIZE(2), .POOL_STRIDE(2)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: direct definition of max pooling on a row-major list of pixels.
  function automatic logic [255:0] ref_pool(input int px[], input int w, input int h, input int c,
                                            input int p, input int s, input bit relu);
    logic [255:0] o = '0;
    int ow = (w - p) / s + 1;
    int oh = (h - p) / s + 1;
    for (int ch = 0; ch < c; ch++)
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          int m = -100000;
          for (int i = 0; i < p; i++)
            for (int j = 0; j < p; j++)
              if (px[(ch*h + oy*s + i)*w + ox*s + j] > m) m = px[(ch*h + oy*s + i)*w + ox*s + j];
          if (relu && m < 0) m = 0;
          o = (o << 8) | 256'(m & 255);
        end
    return o;
  endfunction

  function automatic logic [255:0] pack(input int px[]);
    logic [255:0] f = '0;
    foreach (px[e]) f = (f << 8) | 256'(px[e] & 255);
    return f;
  endfunction

  function automatic void rnd_px(ref int px[], input int n);
    px = new[n];
    foreach (px[e]) begin
      case ($urandom_range(0, 7))
        0:       px[e] = -128;
        1:       px[e] = 127;
        default: px[e] = int'($urandom_range(0, 255)) - 128;
      endcase
    end
  endfunction

  // Full handshake on a and b with identical maps. Optionally scribbles on
  // feature_in mid-run; then holds start in DONE and finally releases it.
  task automatic run_ab(input string tag, input logic [215:0] f, input bit disturb,
                        input logic [95:0] exp_a, input logic [95:0] exp_b);
    int n = 0;
    logic [95:0] ha, hb;
    ia.feature_in = f; ib.feature_in = f;
    ia.calculate_start = 1'b1; ib.calculate_start = 1'b1;
    do begin
      @(posedge clk); #1; n++;
      if (disturb && n == 4) begin
        ia.feature_in = ~f; ib.feature_in = {f[107:0], f[215:108]};
      end
    end while (!ia.calculate_done && n < 60);
    chk({tag, "_lat"}, 256'(n - 1), 256'(13));
    chk({tag, "_done_b"}, 256'(ib.calculate_done), 256'(1));
    chk({tag, "_a"}, 256'(ia.pool_out), 256'(exp_a));
    chk({tag, "_b"}, 256'(ib.pool_out), 256'(exp_b));
    ha = ia.pool_out; hb = ib.pool_out;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_hold_done"}, 256'(ia.calculate_done), 256'(1));
    chk({tag, "_hold_a"}, 256'(ia.pool_out), 256'(ha));
    ia.calculate_start = 1'b0; ib.calculate_start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_rel_done"}, 256'(ia.calculate_done | ib.calculate_done), 256'(0));
    chk({tag, "_rel_b"}, 256'(ib.pool_out), 256'(hb));
    @(posedge clk); #1;
  endtask

  task automatic run_c(input string tag, input logic [127:0] f, input logic [31:0] exp);
    int n = 0;
    ic.feature_in = f;
    ic.calculate_start = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!ic.calculate_done && n < 60);
    chk({tag, "_lat"}, 256'(n - 1), 256'(5));
    chk({tag, "_out"}, 256'(ic.pool_out), 256'(exp));
    ic.calculate_start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_rel_done"}, 256'(ic.calculate_done), 256'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1[] = '{-114,-104,-98, -74,30,-122, 26,116,50,
                 -69,-118,-39, -72,-59,-44, 115,94,-65,
                 -57,-41,-23, -111,127,63, 117,23,105};
    int seq[];
    int px[];
    logic [255:0] f;

    ia.calculate_start = 1'b0; ib.calculate_start = 1'b0; ic.calculate_start = 1'b0;
    ia.feature_in = '0; ib.feature_in = '0; ic.feature_in = '0;

    // Reset state, with start already raised while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 256'({ia.calculate_done, ib.calculate_done, ic.calculate_done}), 256'(0));
    chk("rst_pool", 256'({ia.pool_out, ib.pool_out, ic.pool_out}), 256'(0));
    ia.calculate_start = 1'b1; ib.calculate_start = 1'b1;
    @(posedge clk); #1;
    chk("rst_start_ignored", 256'({ia.calculate_done, ia.pool_out}), 256'(0));
    rst = 1'b0;

    // Reference maps from the upstream conv test.
    f = pack(t1);
    run_ab("t1", f[215:0], 1'b0, 96'h1E1E7474_0000735E_7F7F7F7F,
           96'(ref_pool(t1, 3, 3, 3, 2, 1, 1'b0)));
    chk("t1_b_ch1", 256'(ib.pool_out[63:32]), 256'(32'hC5D9735E));

    // Reset in the middle of a run clears everything asynchronously.
    ia.feature_in = f[215:0]; ib.feature_in = f[215:0];
    ia.calculate_start = 1'b1; ib.calculate_start = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_pool", 256'({ia.pool_out, ib.pool_out}), 256'(0));
    chk("mid_rst_done", 256'(ia.calculate_done), 256'(0));
    @(posedge clk); #1;
    chk("mid_rst_hold", 256'({ia.calculate_done, ia.pool_out}), 256'(0));
    rst = 1'b0;
    run_ab("restart", f[215:0], 1'b0, 96'h1E1E7474_0000735E_7F7F7F7F,
           96'(ref_pool(t1, 3, 3, 3, 2, 1, 1'b0)));

    // Feature bus disturbed during RUN must not affect the result.
    run_ab("disturb", f[215:0], 1'b1, 96'h1E1E7474_0000735E_7F7F7F7F,
           96'(ref_pool(t1, 3, 3, 3, 2, 1, 1'b0)));

    // Signed minimum everywhere.
    px = new[27];
    foreach (px[e]) px[e] = -128;
    f = pack(px);
    run_ab("min", f[215:0], 1'b0, 96'h0, {12{8'h80}});

    // All-equal positive window.
    foreach (px[e]) px[e] = 37;
    f = pack(px);
    run_ab("equal", f[215:0], 1'b0, {12{8'h25}}, {12{8'h25}});

    // Stride-2 geometry on the 4x4 instance.
    seq = new[16];
    foreach (seq[e]) seq[e] = e + 1;
    f = pack(seq);
    run_c("s2", f[127:0], 32'h06080E10);

    // Randomized maps against the reference model.
    for (int it = 0; it < 16; it++) begin
      rnd_px(px, 27);
      f = pack(px);
      run_ab($sformatf("rnd%0d", it), f[215:0], it[0],
             96'(ref_pool(px, 3, 3, 3, 2, 1, 1'b1)), 96'(ref_pool(px, 3, 3, 3, 2, 1, 1'b0)));
    end
    for (int it = 0; it < 6; it++) begin
      rnd_px(px, 16);
      f = pack(px);
      run_c($sformatf("rnd_c%0d", it), f[127:0], 32'(ref_pool(px, 4, 4, 1, 2, 2, 1'b1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
